// File: rtl/pes_bc_bounce_ctrl_if.sv
// pes_bc_bounce_ctrl_if: control/status bundle between pes_bc and its controller.
// master drives bounce_en, dir_req, sweep_clr, Count; slave drives the rest.
interface pes_bc_bounce_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             bounce_en;
  logic             dir_req;
  logic             sweep_clr;
  logic [WIDTH-1:0] Count;
  logic             UpOrDown;
  logic             turn;
  logic             in_window;
  logic [7:0]       sweeps;

  modport master (
    output bounce_en, dir_req, sweep_clr, Count,
    input  UpOrDown, turn, in_window, sweeps
  );

  modport slave (
    input  bounce_en, dir_req, sweep_clr, Count,
    output UpOrDown, turn, in_window, sweeps
  );
endinterface

// File: rtl/pes_bc_bounce_ctrl.sv
// pes_bc_bounce_ctrl: bounce/free direction control for the pes_bc counter.
// Ports: Clk, reset (sync, active-high); bus.slave carries Count in, UpOrDown/turn/in_window/sweeps out.
module pes_bc_bounce_ctrl #(
  parameter int WIDTH = 4,
  parameter int LO    = 0,
  parameter int HI    = 15
) (
  input logic                 Clk,
  input logic                 reset,
  pes_bc_bounce_ctrl_if.slave bus
);
  if (!((LO >= 0) && (LO + 2 <= HI) && (HI <= (2 ** WIDTH) - 1)))
  begin : g_bad_limits
    $error("pes_bc_bounce_ctrl: need LO+2 <= HI <= 2**WIDTH-1");
  end

  // Two spare bits keep the limit compares signed and non-constant
  // even when LO is 0 or HI is the counter maximum.
  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] LO_S  = SW'(LO);
  localparam logic signed [SW-1:0] HI_S  = SW'(HI);
  localparam logic signed [SW-1:0] LO1_S = SW'(LO + 1);
  localparam logic signed [SW-1:0] HI1_S = SW'(HI - 1);

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  logic signed [SW-1:0] cnt;
  dir_t                 dir_q, dir_d;
  logic                 turn_q, turn_d;
  logic                 win_q, win_d;
  logic [7:0]           sw_q, sw_d;

  assign cnt = signed'({2'b00, bus.Count});

  always_comb begin
    dir_d  = dir_q;
    turn_d = 1'b0;
    win_d  = (cnt >= LO_S) && (cnt <= HI_S);
    sw_d   = sw_q;
    if (bus.bounce_en) begin
      // Turning one step early lands Count exactly on the limit
      // in the same cycle the new direction shows.
      unique case (1'b1)
        cnt >= HI_S:
          dir_d = DIR_DN;
        cnt <= LO_S:
          dir_d = DIR_UP;
        (dir_q == DIR_UP) && (cnt == HI1_S):
          dir_d = DIR_DN;
        (dir_q == DIR_DN) && (cnt == LO1_S):
          dir_d = DIR_UP;
        default:
          dir_d = dir_q;
      endcase
      turn_d = (dir_d != dir_q);
    end else begin
      dir_d = dir_t'(bus.dir_req);
    end
    if (bus.sweep_clr) begin
      sw_d = '0;
    end else if (turn_d && (sw_q != 8'hFF)) begin
      sw_d = sw_q + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      dir_q  <= DIR_UP;
      turn_q <= 1'b0;
      win_q  <= 1'b0;
      sw_q   <= '0;
    end else begin
      dir_q  <= dir_d;
      turn_q <= turn_d;
      win_q  <= win_d;
      sw_q   <= sw_d;
    end
  end

  assign bus.UpOrDown  = dir_q;
  assign bus.turn      = turn_q;
  assign bus.in_window = win_q;
  assign bus.sweeps    = sw_q;
endmodule
